// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, forward-select encodings and MDU latency defaults
package cpu_pkg;
    localparam int RA_W = 5;
    localparam int T_W  = 2;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_E    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;
    localparam logic [1:0] FWD_PIPE = 2'b00;
    localparam logic [1:0] FWD_E_M  = 2'b01;
    localparam logic [1:0] FWD_E_W  = 2'b10;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: countdown of remaining multiply/divide busy cycles
module md_busy_tracker
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    md_state_e     state;

    // a new start always reloads, even while busy; otherwise count down to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (start)
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // busy whenever cycles remain
    always_comb begin
        state = (cnt != '0) ? MD_BUSY : MD_IDLE;
        busy  = (state == MD_BUSY);
    end
endmodule

// File: rtl/hazard_unit_md.sv
// hazard_unit_md: Tuse/Tnew stall, forwarding selects, MDU interlock and stall counter
module hazard_unit_md
    import cpu_pkg::*;
#(
    parameter int RA_W        = cpu_pkg::RA_W,
    parameter int T_W         = cpu_pkg::T_W,
    parameter int LINK_REG    = 31,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RA_W-1:0]   D_A1,
    input  logic [RA_W-1:0]   D_A2,
    input  logic [RA_W-1:0]   E_A1,
    input  logic [RA_W-1:0]   E_A2,
    input  logic [RA_W-1:0]   M_A2,
    input  logic [RA_W-1:0]   E_WR,
    input  logic [RA_W-1:0]   M_WR,
    input  logic [RA_W-1:0]   W_WR,
    input  logic [T_W-1:0]    Tuse_rs,
    input  logic [T_W-1:0]    Tuse_rt,
    input  logic [T_W-1:0]    Tnew_E,
    input  logic [T_W-1:0]    Tnew_M,
    input  logic              RegWrite_E,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              check_E,
    input  logic              check_M,
    input  logic              D_md_use,
    input  logic              E_md_start,
    input  logic              E_md_is_div,
    input  logic              perf_clr,
    output logic              stall,
    output logic              E_flush,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic              fwd_M_rt,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);
    localparam logic [RA_W-1:0] LINK = RA_W'(LINK_REG);

    // stall hit: the link register counts as a possible destination when check is set
    function automatic logic hit(input logic we, input logic chk, input logic [RA_W-1:0] a,
                                 input logic [RA_W-1:0] wr);
        return we && a != '0 && (a == wr || (chk && a == LINK));
    endfunction

    // forwarding hit: exact destination only
    function automatic logic fhit(input logic we, input logic [RA_W-1:0] a, input logic [RA_W-1:0] wr);
        return we && a != '0 && a == wr;
    endfunction

    function automatic logic data_stall(input logic [RA_W-1:0] a, input logic [T_W-1:0] tuse,
                                        input logic he_in, input logic hm_in);
        return (he_in && ((tuse == 0 && (Tnew_E == 1 || Tnew_E == 2)) || (tuse == 1 && Tnew_E == 2)))
            || (hm_in && tuse == 0 && Tnew_M == 1) || (a == '0 && 1'b0);
    endfunction

    function automatic logic [1:0] dsel(input logic [RA_W-1:0] a);
        return (fhit(RegWrite_E, a, E_WR) && Tnew_E == 0) ? FWD_E :
               (fhit(RegWrite_M, a, M_WR) && Tnew_M == 0) ? FWD_M :
               fhit(RegWrite_W, a, W_WR) ? FWD_W : FWD_RF;
    endfunction

    function automatic logic [1:0] esel(input logic [RA_W-1:0] a);
        return (fhit(RegWrite_M, a, M_WR) && Tnew_M == 0) ? FWD_E_M :
               fhit(RegWrite_W, a, W_WR) ? FWD_E_W : FWD_PIPE;
    endfunction

    md_busy_tracker #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .busy   (md_busy)
    );

    // stall decision and forward-mux selects, purely from current inputs and MDU state
    always_comb begin
        stall = data_stall(D_A1, Tuse_rs, hit(RegWrite_E, check_E, D_A1, E_WR), hit(RegWrite_M, check_M, D_A1, M_WR))
             || data_stall(D_A2, Tuse_rt, hit(RegWrite_E, check_E, D_A2, E_WR), hit(RegWrite_M, check_M, D_A2, M_WR))
             || (D_md_use && (E_md_start || md_busy));
        E_flush  = stall;
        fwd_D_rs = dsel(D_A1);
        fwd_D_rt = dsel(D_A2);
        fwd_E_rs = esel(E_A1);
        fwd_E_rt = esel(E_A2);
        fwd_M_rt = fhit(RegWrite_W, M_A2, W_WR);
    end

    // saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (perf_clr)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_unit_md.sv
// tb_hazard_unit_md: directed checks of stall, forwarding, MDU interlock and stall counter
module tb_hazard_unit_md;
    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] D_A1, D_A2, E_A1, E_A2, M_A2, E_WR, M_WR, W_WR;
    logic [1:0] Tuse_rs, Tuse_rt, Tnew_E, Tnew_M;
    logic RegWrite_E, RegWrite_M, RegWrite_W, check_E, check_M;
    logic D_md_use, E_md_start, E_md_is_div, perf_clr;
    logic stall, E_flush, fwd_M_rt, md_busy;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic [31:0] stall_cnt;
    logic s4_stall, s4_flush, s4_fwd_M_rt, s4_md_busy;
    logic [1:0] s4_fwd_D_rs, s4_fwd_D_rt, s4_fwd_E_rs, s4_fwd_E_rt;
    logic [3:0] s4_stall_cnt;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit_md dut (
        .clk(clk), .reset_n(reset_n), .D_A1(D_A1), .D_A2(D_A2), .E_A1(E_A1), .E_A2(E_A2),
        .M_A2(M_A2), .E_WR(E_WR), .M_WR(M_WR), .W_WR(W_WR), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M),
        .RegWrite_W(RegWrite_W), .check_E(check_E), .check_M(check_M), .D_md_use(D_md_use),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .perf_clr(perf_clr),
        .stall(stall), .E_flush(E_flush), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
        .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    hazard_unit_md #(.PERF_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .D_A1(D_A1), .D_A2(D_A2), .E_A1(E_A1), .E_A2(E_A2),
        .M_A2(M_A2), .E_WR(E_WR), .M_WR(M_WR), .W_WR(W_WR), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M),
        .RegWrite_W(RegWrite_W), .check_E(check_E), .check_M(check_M), .D_md_use(D_md_use),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .perf_clr(perf_clr),
        .stall(s4_stall), .E_flush(s4_flush), .fwd_D_rs(s4_fwd_D_rs), .fwd_D_rt(s4_fwd_D_rt),
        .fwd_E_rs(s4_fwd_E_rs), .fwd_E_rt(s4_fwd_E_rt), .fwd_M_rt(s4_fwd_M_rt), .md_busy(s4_md_busy),
        .stall_cnt(s4_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {D_A1, D_A2, E_A1, E_A2, M_A2, E_WR, M_WR, W_WR} = '0;
        {Tuse_rs, Tuse_rt, Tnew_E, Tnew_M} = '0;
        {RegWrite_E, RegWrite_M, RegWrite_W, check_E, check_M} = '0;
        {D_md_use, E_md_start, E_md_is_div, perf_clr} = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        #12;
        check("rst_stall", stall, 0);
        check("rst_flush", E_flush, 0);
        check("rst_fwd", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, 1'b0, fwd_M_rt}, 0);
        check("rst_busy", md_busy, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_cnt4", s4_stall_cnt, 0);
        reset_n = 1'b1;
        cycle();
        // load in E, branch in D reading it
        RegWrite_E = 1; E_WR = 8; Tnew_E = 2; D_A1 = 8; Tuse_rs = 0; #1;
        check("lw_beq_stall", stall, 1);
        check("lw_beq_flush", E_flush, 1);
        E_WR = 0; D_A1 = 0; #1;
        check("r0_no_stall", stall, 0);
        // conditional destination may be the link register
        clear_inputs();
        RegWrite_E = 1; check_E = 1; E_WR = 5; Tnew_E = 1; D_A1 = 31; Tuse_rs = 0; #1;
        check("link_stall", stall, 1);
        check_E = 0; #1;
        check("link_off", stall, 0);
        // rt path: Tuse 1 vs Tnew_E 2 stalls, Tnew_E 1 does not
        clear_inputs();
        RegWrite_E = 1; E_WR = 5; D_A2 = 5; Tuse_rt = 1; Tnew_E = 2; #1;
        check("rt_t1_n2", stall, 1);
        Tnew_E = 1; #1;
        check("rt_t1_n1", stall, 0);
        // M-stage producer with Tnew_M 1
        clear_inputs();
        RegWrite_M = 1; M_WR = 7; Tnew_M = 1; D_A2 = 7; Tuse_rt = 0; #1;
        check("m_stall", stall, 1);
        Tuse_rt = 1; #1;
        check("m_no_stall", stall, 0);
        // forwarding priorities
        clear_inputs();
        M_WR = 9; Tnew_M = 0; RegWrite_M = 1; W_WR = 9; RegWrite_W = 1; E_A1 = 9; #1;
        check("fwd_E_rs_M", fwd_E_rs, 2'b01);
        RegWrite_M = 0; #1;
        check("fwd_E_rs_W", fwd_E_rs, 2'b10);
        D_A2 = 9; E_WR = 9; Tnew_E = 0; RegWrite_E = 1; #1;
        check("fwd_D_rt_E", fwd_D_rt, 2'b01);
        RegWrite_E = 0; RegWrite_M = 1; #1;
        check("fwd_D_rt_M", fwd_D_rt, 2'b10);
        RegWrite_M = 0; #1;
        check("fwd_D_rt_W", fwd_D_rt, 2'b11);
        M_A2 = 9; #1;
        check("fwd_M_rt_W", fwd_M_rt, 1);
        check_E = 1; RegWrite_E = 1; E_WR = 3; D_A1 = 31; W_WR = 0; #1;
        check("fwd_no_link", fwd_D_rs, 2'b00);
        // divide with a waiting md instruction in D
        clear_inputs();
        perf_clr = 1; cycle(); perf_clr = 0;
        check("cnt_clr", stall_cnt, 0);
        D_md_use = 1; E_md_start = 1; E_md_is_div = 1; #1;
        check("div_start_stall", stall, 1);
        check("div_start_idle", md_busy, 0);
        cycle();
        E_md_start = 0; E_md_is_div = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("div_busy%0d", i), {md_busy, stall}, 2'b11);
            cycle();
        end
        check("div_done_busy", md_busy, 0);
        check("div_done_stall", stall, 0);
        check("div_cnt", stall_cnt, 11);
        // multiply aborted by reset at busy cycle 3
        clear_inputs();
        E_md_start = 1; cycle(); E_md_start = 0;
        cycle(); cycle();
        check("mult_busy3", md_busy, 1);
        #2 reset_n = 0; #1;
        check("abort_busy", md_busy, 0);
        check("abort_cnt", stall_cnt, 0);
        #2 reset_n = 1;
        D_md_use = 1; #1;
        check("post_rst_nostall", stall, 0);
        cycle();
        // saturation on the 4-bit counter
        clear_inputs();
        RegWrite_E = 1; E_WR = 8; Tnew_E = 2; D_A1 = 8;
        repeat (20) cycle();
        check("sat4", s4_stall_cnt, 15);
        check("cnt32_20", stall_cnt, 20);
        perf_clr = 1; cycle();
        check("clr_wins4", s4_stall_cnt, 0);
        check("clr_wins32", stall_cnt, 0);
        perf_clr = 0; cycle();
        check("after_clr", s4_stall_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
